// File: rtl/free_list_pkg.sv
// Shared rename-stage definitions: physical register file sizing and the PREG index type.
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif

package free_list_pkg;
  typedef logic [`PHYS_REG_IDX_SZ:0] PREG;
endpackage

// File: rtl/free_list.sv
// Circular-buffer free list of physical register indices for rename/retire/restore.
// Optional: FREE_LIST_BYPASS_EN (empty-list free-to-alloc bypass), DEBUG_PRINT (negedge dump).
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif

module free_list
  import free_list_pkg::*;
#(
  parameter int PHYS_REGS = `PHYS_REG_SZ,
  parameter int IDX_W     = `PHYS_REG_IDX_SZ + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_req,
  output logic                         alloc_valid,
  output logic [IDX_W-1:0]             alloc_preg,
  input  logic                         free_enable,
  input  logic [IDX_W-1:0]             free_preg_idx,
  input  logic                         restore_enable,
  output logic [$clog2(PHYS_REGS):0]   free_count
);

  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(PHYS_REGS) + 1;

  logic [IDX_W-1:0] entries [PHYS_REGS];
  logic [PTR_W-1:0] head, tail, retire_head;
  logic [PTR_W-1:0] head_nxt, tail_nxt, retire_head_nxt;
  logic             bypass, do_alloc, push;

  assign free_count = CNT_W'(tail - head);

  always_comb begin
    bypass = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    bypass = (free_count == '0) && free_enable && (free_preg_idx != '0) && !restore_enable;
`endif
    alloc_valid = ((free_count != '0) && !restore_enable) || bypass;
    alloc_preg  = bypass ? free_preg_idx : entries[head[IDX_W-1:0]];
  end

  // Preg 0 is the shared reset mapping and never re-enters the list.
  assign do_alloc = alloc_req && alloc_valid;
  assign push     = free_enable && (free_preg_idx != '0);

  always_comb begin
    tail_nxt        = tail + PTR_W'(push);
    retire_head_nxt = retire_head + PTR_W'(free_enable);
    if (restore_enable)
      head_nxt = retire_head + PTR_W'(free_enable);
    else
      head_nxt = head + PTR_W'(do_alloc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      retire_head <= '0;
      tail        <= PTR_W'(PHYS_REGS - 1);
      for (int i = 0; i < PHYS_REGS; i++)
        entries[i] <= IDX_W'(i + 1);
    end else begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      retire_head <= retire_head_nxt;
      if (push)
        entries[tail[IDX_W-1:0]] <= free_preg_idx;
    end
  end

  // Retiring with no outstanding allocation, or overfilling, means upstream is broken.
  a_retire_underflow: assert property (@(posedge clk) disable iff (reset)
    !(free_enable && (retire_head == head)));
  a_push_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (free_count == CNT_W'(PHYS_REGS))));

`ifdef DEBUG_PRINT
  function automatic void print_free_list();
    $display("free_list head=%0d tail=%0d retire_head=%0d count=%0d",
             head, tail, retire_head, free_count);
    for (int i = 0; i < PHYS_REGS; i++)
      $display("  [%0d] %0d", i, entries[i]);
  endfunction

  always @(negedge clk) print_free_list();
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus queues expected outputs, a negedge monitor compares.
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req, free_enable, restore_enable;
  logic [5:0] free_preg_idx;
  logic       alloc_valid;
  logic [5:0] alloc_preg;
  logic [6:0] free_count;

  free_list dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_valid   (alloc_valid),
    .alloc_preg    (alloc_preg),
    .free_enable   (free_enable),
    .free_preg_idx (free_preg_idx),
    .restore_enable(restore_enable),
    .free_count    (free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         cv;
    bit         av;
    bit         cp;
    logic [5:0] ap;
    bit         cc;
    logic [6:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge clk) cyc++;

  // Monitor: every negedge, pop the expectations registered for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s expectation for cycle %0d not sampled (now %0d)", nm, e.cyc, cyc);
      end else begin
        if (e.cv) begin
          n_cmp++;
          if (alloc_valid !== e.av) begin
            n_bad++;
            $display("FAIL %s alloc_valid got %0b want %0b", nm, alloc_valid, e.av);
          end
        end
        if (e.cp) begin
          n_cmp++;
          if (alloc_preg !== e.ap) begin
            n_bad++;
            $display("FAIL %s alloc_preg got %0d want %0d", nm, alloc_preg, e.ap);
          end
        end
        if (e.cc) begin
          n_cmp++;
          if (free_count !== e.fc) begin
            n_bad++;
            $display("FAIL %s free_count got %0d want %0d", nm, free_count, e.fc);
          end
        end
      end
    end
  end

  task automatic expect_out(input string nm, input bit cv, input bit av,
                            input bit cp, input int ap, input bit cc, input int fc);
    exp_t e;
    e.cyc = cyc; e.cv = cv; e.av = av;
    e.cp = cp; e.ap = 6'(ap); e.cc = cc; e.fc = 7'(fc);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input bit ar, input bit fe, input int fi, input bit re);
    @(posedge clk);
    #1;
    alloc_req      = ar;
    free_enable    = fe;
    free_preg_idx  = 6'(fi);
    restore_enable = re;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    alloc_req = 0; free_enable = 0; free_preg_idx = 0; restore_enable = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alloc_req = 0; free_enable = 0; free_preg_idx = 0; restore_enable = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and full drain 1..63
    step(0, 0, 0, 0);
    expect_out("reset_state", 1, 1, 1, 1, 1, 63);
    for (int i = 1; i <= 63; i++) begin
      step(1, 0, 0, 0);
      expect_out("drain_seq", 1, 1, 1, i, 1, 64 - i);
    end
    step(0, 0, 0, 0);
    expect_out("drained", 1, 0, 0, 0, 1, 0);

    // Free into an empty list while dispatch keeps asking
    step(1, 1, 5, 0);
`ifdef FREE_LIST_BYPASS_EN
    expect_out("empty_free_same", 1, 1, 1, 5, 1, 0);
    step(0, 0, 0, 0);
    expect_out("empty_free_next", 1, 0, 0, 0, 1, 0);
`else
    expect_out("empty_free_same", 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0);
    expect_out("empty_free_next", 1, 1, 1, 5, 1, 1);
`endif

    // Free of preg 0 then restore
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0);
      expect_out("rst0_alloc", 1, 1, 1, i, 1, 64 - i);
    end
    step(0, 1, 0, 0);
    expect_out("free_zero", 0, 0, 0, 0, 1, 60);
    step(0, 0, 0, 1);
    expect_out("restore_cycle", 1, 0, 0, 0, 1, 60);
    step(0, 0, 0, 0);
    expect_out("after_restore", 1, 1, 1, 2, 1, 62);

    // Restore with same-cycle free of preg 9
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0);
      expect_out("rst9_alloc", 1, 1, 1, i, 1, 64 - i);
    end
    step(1, 1, 9, 1);
    expect_out("restore_free_cycle", 1, 0, 0, 0, 1, 60);
    step(0, 0, 0, 0);
    expect_out("restore_free_after", 1, 1, 1, 2, 1, 63);
    for (int i = 1; i <= 62; i++) begin
      step(1, 0, 0, 0);
      expect_out("restore_tail_walk", 1, 1, 1, i + 1, 1, 64 - i);
    end
    step(1, 0, 0, 0);
    expect_out("tail_holds_9", 1, 1, 1, 9, 1, 1);
    step(0, 0, 0, 0);
    expect_out("restore_drained", 1, 0, 0, 0, 1, 0);

    // Steady alloc+free of preg 7 across pointer wrap, then drain
    do_reset();
    step(1, 0, 0, 0);
    expect_out("wrap_first", 1, 1, 1, 1, 1, 63);
    for (int k = 1; k <= 70; k++) begin
      step(1, 1, 7, 0);
      expect_out("wrap_steady", 1, 1, 1, (k <= 62) ? k + 1 : 7, 1, 62);
    end
    for (int i = 0; i < 62; i++) begin
      step(1, 0, 0, 0);
      expect_out("wrap_drain", 1, 1, 1, 7, 1, 62 - i);
    end
    step(0, 0, 0, 0);
    expect_out("wrap_empty", 1, 0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of an allocation burst
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0);
      expect_out("async_pre", 1, 1, 1, i, 1, 64 - i);
    end
    step(1, 0, 0, 0);
    #2 reset = 1'b1;
    expect_out("async_reset", 1, 1, 1, 1, 1, 63);
    step(0, 0, 0, 0);
    reset = 1'b0;
    expect_out("async_release", 1, 1, 1, 1, 1, 63);

    repeat (2) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      string nm;
      void'(exp_q.pop_front());
      nm = name_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s expectation never checked", nm);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Circular-buffer free list of physical register indices for the rename stage. It supplies a new destination physical register (`new_dest_pr_idx`) to the map table at dispatch and accepts the old destination physical register back from the ROB at retirement. On a mispredict restore it returns all speculatively allocated registers in one cycle, in step with the map table's copy of the architectural map.

## Interface
- `PHYS_REGS`, default `` `PHYS_REG_SZ `` (64): number of physical registers; power of two.
- `IDX_W`, default `` `PHYS_REG_IDX_SZ+1 ``: physical index width, equal to $clog2(PHYS_REGS).
- Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high.
- `alloc_req` in 1: dispatch consumes the head entry this cycle. Asserted only for instructions whose dest is not x0.
- `alloc_valid` out 1: head entry is available.
- `alloc_preg` out IDX_W: physical register offered. It drives the map table's `new_dest_pr_idx`.
- `free_enable` in 1: ROB retires an instruction with dest not x0.
- `free_preg_idx` in IDX_W: old destination preg of the retiring instruction.
- `restore_enable` in 1: mispredict squash, asserted in the same cycle as the map table restore.
- `free_count` out $clog2(PHYS_REGS)+1: number of entries currently free.

## Operation
- Storage: PHYS_REGS entries of IDX_W bits.
- Pointers: `head`, `tail` and `retire_head`, each IDX_W+1 bits wide, where the MSB is the wrap bit.
- `free_count` = `tail` − `head`.
- Reset state:
  - Entries 0..PHYS_REGS−2 hold pregs 1..PHYS_REGS−1. Preg 0 is never in the list.
  - `head` = `retire_head` = 0.
  - `tail` = PHYS_REGS−1.
  - Outputs after reset: `alloc_valid`=1, `alloc_preg`=1, `free_count`=PHYS_REGS−1.
- Allocate: if `alloc_req` && `alloc_valid`, `head` increments by 1. `alloc_req` while `alloc_valid`=0 is ignored.
- Free: if `free_enable`:
  - `retire_head` increments by 1, because the retiring instruction's allocation is now committed.
  - If `free_preg_idx` ≠ 0, that value is written at `tail` and `tail` increments by 1.
  - If `free_preg_idx` = 0, nothing is pushed. Preg 0 is the shared reset mapping and is never recycled.
- Restore: if `restore_enable`, `head` is set to `retire_head`, or to `retire_head`+1 if `free_enable` is asserted in the same cycle. Any allocate in that cycle is discarded. The tail push from a same-cycle free still happens.
- `alloc_valid` = (`free_count` ≠ 0) && !`restore_enable`.
- `alloc_preg` = entry at `head[IDX_W−1:0]`.
- Allocate and free in the same cycle: both pointers advance and `free_count` is unchanged.
- Wrap-around: pointer low bits index storage modulo PHYS_REGS; the MSB toggles on wrap.
- Illegal inputs (simulation assertions, no recovery):
  - `free_enable` when `retire_head` == `head`.
  - A push when `free_count` == PHYS_REGS.

## Timing
- `alloc_valid` and `alloc_preg` are combinational from registered state. The only same-cycle input path is `restore_enable`, plus the bypass path when the macro is enabled.
- A freed preg is written at posedge. When the list was empty, it appears at `alloc_preg` on the following cycle.
- A restore takes effect at posedge. Allocation resumes the next cycle.
- Asserting `reset` mid-operation immediately forces the reset state, regardless of `clk`.

## Configuration
- `FREE_LIST_BYPASS_EN` defined: when `free_count`==0, `free_enable`=1, `free_preg_idx`≠0 and `restore_enable`=0:
  - `alloc_valid`=1 and `alloc_preg`=`free_preg_idx` in the same cycle.
  - If allocated, `head` and `tail` both advance and `free_count` stays 0.
- `FREE_LIST_BYPASS_EN` undefined: no bypass, and an empty list stalls dispatch for at least one cycle.

## Structure
- Shared package/header: `` `PHYS_REG_SZ ``, `` `PHYS_REG_IDX_SZ `` and the existing `PREG` typedef. No new shared typedefs.
- Single module. Pointer arithmetic is simple enough that no sub-module is warranted.
- A `print_free_list()` debug dump is called on negedge under `DEBUG_PRINT`.

## Test plan
- Reset, then 63 consecutive `alloc_req` → `alloc_preg` = 1,2,…,63 on successive cycles. After that, `alloc_valid`=0 and `free_count`=0.
- List empty, `free_enable` with `free_preg_idx`=5:
  - Without the macro: the next cycle gives `alloc_valid`=1, `alloc_preg`=5, `free_count`=1.
  - With the macro: the same cycle gives `alloc_valid`=1, `alloc_preg`=5.
- Allocate 1,2,3, then free with idx 0, then `restore_enable` → `alloc_preg`=2, `free_count`=62, and nothing was pushed for preg 0.
- Allocate 1,2,3, then `restore_enable` and `free_enable`(idx 9) in the same cycle → `head` points at preg 2, 9 is appended at the tail, and `free_count`=63.
- Allocate and free (idx 7) together 70 times → `free_count` constant and pointers wrap correctly. After the list drains, 7 is allocated in FIFO order.
- Assert `reset` asynchronously mid-allocation → outputs return to `alloc_preg`=1 and `free_count`=63 immediately, before the next clock edge.
